// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter slice.
// Holds the one-shot FSM state encoding and the direction literals.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/cnt_next_calc.sv
// Combinational next-count and terminal detection for the modulo counter.
// Build option: COUNTER_SAT_EN makes terminal steps hold instead of wrapping.
module cnt_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_at_term
);

  // Width-exact constants keep MODULUS == 2**WIDTH from overflowing.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  always_comb begin
    o_at_term = (i_up == DIR_UP) ? (i_q == MAX_Q) : (i_q == '0);
    if (o_at_term) begin
`ifdef COUNTER_SAT_EN
      o_next_q = i_q;
`else
      o_next_q = (i_up == DIR_DOWN) ? MAX_Q : '0;
`endif
    end else begin
      o_next_q = (i_up == DIR_UP) ? (i_q + ONE_Q) : (i_q - ONE_Q);
    end
  end

endmodule : cnt_next_calc

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo-N counter with load, clear, flags and one-shot FSM.
// Build option: COUNTER_SAT_EN selects saturating terminal steps (see cnt_next_calc).
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             start,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_done;
  logic             r_load_err;

  cnt_state_t       w_state_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_done_next;
  logic             w_load_err_next;

  logic [WIDTH-1:0] w_step_q;
  logic             w_at_term;
  logic             w_step_ok;
  logic             w_load_bad;

  cnt_next_calc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next_calc (
    .i_q       (r_q),
    .i_up      (up),
    .o_next_q  (w_step_q),
    .o_at_term (w_at_term)
  );

  assign w_load_bad = ({1'b0, load_val} >= MOD_EXT);
  assign w_step_ok  = en && (!oneshot || (r_state == CNT_RUN));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_next    = r_state;
    w_q_next        = r_q;
    w_wrap_next     = 1'b0;
    w_done_next     = r_done;
    w_load_err_next = 1'b0;

    if (clr) begin
      w_q_next     = '0;
      w_done_next  = 1'b0;
      w_state_next = CNT_IDLE;
    end else if (load) begin
      w_q_next        = w_load_bad ? MAX_Q : load_val;
      w_load_err_next = w_load_bad;
      w_done_next     = 1'b0;
      w_state_next    = CNT_IDLE;
    end else begin
      if (!oneshot) begin
        w_state_next = CNT_IDLE;
        w_done_next  = 1'b0;
      end else begin
        unique case (r_state)
          CNT_IDLE: if (start) w_state_next = CNT_RUN;
          CNT_RUN: begin
            if (w_step_ok && w_at_term) begin
              w_state_next = CNT_DONE;
              w_done_next  = 1'b1;
            end
          end
          CNT_DONE: begin
            if (start) begin
              w_state_next = CNT_RUN;
              w_done_next  = 1'b0;
            end
          end
          default: w_state_next = CNT_IDLE;
        endcase
      end

      if (w_step_ok) begin
        w_q_next    = w_step_q;
        w_wrap_next = w_at_term;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all bits update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= CNT_IDLE;
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_q        <= w_q_next;
      r_wrap     <= w_wrap_next;
      r_done     <= w_done_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign q        = r_q;
  assign tc       = w_at_term;
  assign wrap     = r_wrap;
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10).
// Arithmetic reference model plus directed vectors with literal expectations.
module tb_updown_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, up = 1'b1, oneshot = 1'b0, start = 1'b0;
  logic         clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc, wrap, done, load_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Reference model state: count, pulses, and "armed"/"finished" flags.
  int m_q = 0, m_wrap = 0, m_lerr = 0, m_done = 0, m_run = 0;

  updown_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .oneshot  (oneshot),
    .start    (start),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = 0; m_wrap = 0; m_lerr = 0; m_done = 0; m_run = 0;
    end else if (clr) begin
      m_q = 0; m_wrap = 0; m_lerr = 0; m_done = 0; m_run = 0;
    end else if (load) begin
      m_wrap = 0;
      m_lerr = (int'(load_val) >= MOD) ? 1 : 0;
      m_q    = m_lerr ? MOD - 1 : int'(load_val);
      m_done = 0; m_run = 0;
    end else begin
      automatic bit allowed = en && (!oneshot || m_run != 0);
      m_wrap = 0; m_lerr = 0;
      if (!oneshot) begin
        m_run = 0; m_done = 0;
      end else if (start && m_run == 0) begin
        m_run = 1; m_done = 0;
      end
      if (allowed) begin
        automatic int limit = up ? MOD - 1 : 0;
        if (m_q == limit) begin
          m_wrap = 1;
`ifndef COUNTER_SAT_EN
          m_q = up ? 0 : MOD - 1;
`endif
          if (oneshot) begin
            m_run = 0; m_done = 1;
          end
        end else begin
          m_q = up ? m_q + 1 : m_q - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("q", int'(q), m_q);
      check("tc", int'(tc), (up ? (m_q == MOD - 1) : (m_q == 0)) ? 1 : 0);
      check("wrap", int'(wrap), m_wrap);
      check("done", int'(done), m_done);
      check("load_err", int'(load_err), m_lerr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic do_load(input int v);
    load_val = W'(v);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    automatic logic [11:0] dir_pat = 12'b1011_0010_1101;

    repeat (2) @(negedge clk);
    #2;
    check("reset_q", int'(q), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b1;
    chk_on = 1'b1;

    // Up count 0..9 and wrap to 0.
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("up_q", int'(q), (i + 1) % 10);
      check("up_wrap", int'(wrap), (i == 9) ? 1 : 0);
      if (i == 8) check("up_tc9", int'(tc), 1);
    end
    en = 1'b0;

    // Down from 3 across zero, then out-of-range load.
    do_load(3);
    check("load3", int'(q), 3);
    up = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("down_q", int'(q), (i == 3) ? 9 : 2 - i);
      check("down_wrap", int'(wrap), (i == 3) ? 1 : 0);
    end
    en = 1'b0;
    do_load(12);
    check("load12_q", int'(q), 9);
    check("load12_err", int'(load_err), 1);
    cyc();
    check("load_err_pulse", int'(load_err), 0);

    // Asynchronous reset between edges while q=7.
    do_load(7);
    check("pre_reset_q", int'(q), 7);
    #1 rst = 1'b0;
    #1;
    check("async_q", int'(q), 0);
    check("async_wrap", int'(wrap), 0);
    check("async_done", int'(done), 0);
    check("async_lerr", int'(load_err), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;

    // One-shot: arm, count to terminal, hold, restart.
    oneshot = 1'b1; up = 1'b1; en = 1'b1; start = 1'b1;
    cyc();
    check("os_arm_only", int'(q), 0);
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check("os_q", int'(q), i);
    end
    cyc();
    check("os_term_q", int'(q), 0);
    check("os_term_wrap", int'(wrap), 1);
    check("os_done", int'(done), 1);
    repeat (5) cyc();
    check("os_hold_q", int'(q), 0);
    check("os_hold_done", int'(done), 1);
    start = 1'b1;
    cyc();
    check("os_restart_done", int'(done), 0);
    check("os_restart_q", int'(q), 0);
    start = 1'b0;
    cyc();
    check("os_resume_q", int'(q), 1);
    start = 1'b1;
    cyc();
    check("os_start_in_run", int'(q), 2);
    start = 1'b0;
    repeat (8) cyc();
    check("os_done2", int'(done), 1);
    en = 1'b0; oneshot = 1'b0;
    cyc();
    check("os_leave_done", int'(done), 0);

    // Priority: clr over load over step; load over step.
    do_load(5);
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd3;
    cyc();
    check("prio_clr", int'(q), 0);
    clr = 1'b0; load_val = 4'd4;
    cyc();
    check("prio_load", int'(q), 4);
    load = 1'b0; en = 1'b0;

    // Terminal behaviour from 8 counting up three times.
    do_load(8);
    up = 1'b1; en = 1'b1;
    cyc();
    check("term_q1", int'(q), 9);
    check("term_w1", int'(wrap), 0);
    cyc();
`ifdef COUNTER_SAT_EN
    check("sat_q2", int'(q), 9);
    check("sat_w2", int'(wrap), 1);
    cyc();
    check("sat_q3", int'(q), 9);
    check("sat_w3", int'(wrap), 1);
`else
    check("wrap_q2", int'(q), 0);
    check("wrap_w2", int'(wrap), 1);
    cyc();
    check("wrap_q3", int'(q), 1);
    check("wrap_w3", int'(wrap), 0);
`endif

    // Direction and enable toggling mid-count, checked by the model.
    for (int i = 0; i < 12; i++) begin
      up = dir_pat[i];
      en = (i % 3 != 2);
      cyc();
    end
    en = 1'b0;
    cyc();

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_updown_mod_counter
